// File: rtl/fmap_streamer_if.sv
// Bundles the SRAM read port and the pixel stream that fmap_streamer drives.
interface fmap_streamer_if #(
    parameter int AW = 10,
    parameter int DW = 24
);
    logic          mem_ren;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata;
    logic          valid;
    logic [DW-1:0] D;

    modport master (
        output mem_ren, mem_addr, valid, D,
        input  mem_rdata
    );

    modport slave (
        input  mem_ren, mem_addr, valid, D,
        output mem_rdata
    );
endinterface

// File: rtl/fmap_streamer.sv
// Streams an NH x NW feature map out of 1-cycle-latency SRAM in raster order,
// with ROW_GAP idle cycles between rows and PAD trailing rows of zero pixels.
module fmap_streamer #(
    parameter int KER_SIZE = 3,
    parameter int BITWIDTH = 8,
    parameter int NFMAPS   = 3,
    parameter int NW       = 32,
    parameter int NH       = 32,
    parameter int PAD      = 1,
    parameter int ROW_GAP  = 1,
    parameter int AW       = 10
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            start,
    input  logic            hold,
    input  logic [AW-1:0]   base_addr,
    output logic            busy,
    output logic            done,
    fmap_streamer_if.master bus
);
    localparam int DW   = NFMAPS * BITWIDTH;
    localparam int ROWS = NH + PAD;
    localparam int CW   = (NW > 1) ? $clog2(NW) : 1;
    localparam int RW   = $clog2(ROWS + 1);
    localparam int GW   = (ROW_GAP > 1) ? $clog2(ROW_GAP) : 1;
    localparam logic [GW-1:0] GAP_LAST = (ROW_GAP > 0) ? GW'(ROW_GAP - 1) : '0;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] ROW   = 3'd1;
    localparam logic [2:0] GAP   = 3'd2;
    localparam logic [2:0] BPAD  = 3'd3;
    localparam logic [2:0] DRAIN = 3'd4;

    if (KER_SIZE <= PAD) begin : g_cfg_check
        $error("fmap_streamer: KER_SIZE must exceed PAD");
    end

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          s1_v_q, s1_v_d;
    logic          s1_pad_q, s1_pad_d;
    logic          valid_q, valid_d;
    logic [DW-1:0] d_q, d_d;
    logic          done_q, done_d;
    logic          issue, issue_pad;
    logic          row_end, last_row;

    assign row_end  = (col_q == CW'(NW - 1));
    assign last_row = (row_q == RW'(ROWS - 1));

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        gap_d     = gap_q;
        addr_d    = addr_q;
        done_d    = 1'b0;
        issue     = 1'b0;
        issue_pad = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ROW;
                    addr_d  = base_addr;
                    col_d   = '0;
                    row_d   = '0;
                    gap_d   = '0;
                end
            end
            ROW, BPAD: begin
                if (!hold) begin
                    issue     = 1'b1;
                    issue_pad = (state_q == BPAD);
                    // Image rows are contiguous, so the address simply increments.
                    if (state_q == ROW) addr_d = addr_q + AW'(1);
                    if (row_end) begin
                        col_d = '0;
                        row_d = row_q + RW'(1);
                        if (last_row)                 state_d = DRAIN;
                        else if (ROW_GAP > 0)         state_d = GAP;
                        else if (row_q < RW'(NH - 1)) state_d = ROW;
                        else                          state_d = BPAD;
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end
            end
            GAP: begin
                if (!hold) begin
                    if (gap_q == GAP_LAST) begin
                        gap_d   = '0;
                        state_d = (row_q < RW'(NH)) ? ROW : BPAD;
                    end else begin
                        gap_d = gap_q + GW'(1);
                    end
                end
            end
            DRAIN: begin
                // Last issue sits in stage 1 here; once it moves to the output, finish.
                if (!s1_v_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        s1_v_d   = issue;
        s1_pad_d = issue_pad;
        valid_d  = s1_v_q;
        d_d      = (s1_v_q && !s1_pad_q) ? bus.mem_rdata : '0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            col_q    <= '0;
            row_q    <= '0;
            gap_q    <= '0;
            addr_q   <= '0;
            s1_v_q   <= 1'b0;
            s1_pad_q <= 1'b0;
            valid_q  <= 1'b0;
            d_q      <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            row_q    <= row_d;
            gap_q    <= gap_d;
            addr_q   <= addr_d;
            s1_v_q   <= s1_v_d;
            s1_pad_q <= s1_pad_d;
            valid_q  <= valid_d;
            d_q      <= d_d;
            done_q   <= done_d;
        end
    end

    assign bus.mem_ren  = issue && !issue_pad;
    assign bus.mem_addr = addr_q;
    assign bus.valid    = valid_q;
    assign bus.D        = d_q;
    assign busy         = (state_q != IDLE);
    assign done         = done_q;
endmodule
